pad_bank_arb: RTL and testbench

PAD_BANK_ARB -- requirements
Module: pad_bank_arb

---
 rtl/pad_bank_arb.sv | 129 ++++++++++++
 tb/tb_pad_bank_arb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_bank_arb.sv
// Shared tri-state pad bank arbiter.
// Several requesters compete for one bank of PADW bidirectional pads. A single
// owner at a time drives the pad outputs; between owners every pad driver is
// forced off for TA_CYC turnaround cycles so two owners never fight on the pads.
// The pad input path is a plain two-flop synchroniser broadcast to everybody.
//
// Request/grant semantics: req_i[k] is a level request. A grant is issued only
// from IDLE, is registered, and is held for as long as the owner keeps its
// req_i bit high; dropping it releases the bank at the next edge. There is no
// preemption and gnt_o is always zero or one-hot.
module pad_bank_arb #(
  parameter int NREQ   = 4,
  parameter int PADW   = 8,
  parameter int TA_CYC = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NREQ-1:0]      req_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 busy_o,
  input  logic [NREQ*PADW-1:0] out_i,
  input  logic [NREQ*PADW-1:0] oe_i,
  output logic [PADW-1:0]      pad_c2p_o,
  output logic [PADW-1:0]      pad_c2p_en_o,
  input  logic [PADW-1:0]      pad_p2c_i,
  output logic [PADW-1:0]      in_o,
  output logic [1:0]           state_o
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  logic [1:0]      state;
  logic [3:0]      cnt;
  logic [IDXW-1:0] last_owner;
  logic            pick_valid;
  logic [IDXW-1:0] pick_idx;
  logic [NREQ-1:0] pick_onehot;
  int unsigned     cand;
  logic [PADW-1:0] owner_out;
  logic [PADW-1:0] owner_oe;
  logic [PADW-1:0] sync_q1;
  logic [PADW-1:0] sync_q2;

  // Round-robin search: first requester at or after last_owner+1, wrapping.
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    cand        = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = 32'(last_owner) + 32'(i) + 32'd1;
      if (cand >= 32'(NREQ)) cand = cand - 32'(NREQ);
      if (!pick_valid && req_i[cand[IDXW-1:0]]) begin
        pick_valid                    = 1'b1;
        pick_idx                      = cand[IDXW-1:0];
        pick_onehot[cand[IDXW-1:0]]   = 1'b1;
      end
    end
  end

  // Arbitration FSM: IDLE -> GRANT while owner requests -> TURN for TA_CYC cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      gnt_o      <= '0;
      cnt        <= '0;
      last_owner <= IDXW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_o      <= pick_onehot;
            last_owner <= pick_idx;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (!req_i[last_owner]) begin
            gnt_o <= '0;
            cnt   <= 4'(TA_CYC);
            state <= TURN;
          end
        end
        TURN: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt_o <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Two-flop synchroniser on the asynchronous pad inputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= pad_p2c_i;
      sync_q2 <= sync_q1;
    end
  end

  assign owner_out = out_i[int'(last_owner) * PADW +: PADW];
  assign owner_oe  = oe_i[int'(last_owner) * PADW +: PADW];

  // Pad drive: only the registered owner drives, everything is off outside GRANT.
  always_comb begin
    pad_c2p_o    = '0;
    pad_c2p_en_o = '0;
    if (state == GRANT) begin
      pad_c2p_o    = owner_out;
      pad_c2p_en_o = owner_oe & {PADW{gnt_o[last_owner]}};
    end
  end

  assign busy_o  = (state == GRANT) || (state == TURN);
  assign in_o    = sync_q2;
  assign state_o = state;

endmodule

// File: tb/tb_pad_bank_arb.sv
// Bench for pad_bank_arb: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a cycle-level reference model.
module tb_pad_bank_arb;

  localparam int NREQ = 4;
  localparam int PADW = 8;
  localparam int TA   = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic [NREQ*PADW-1:0] out_v;
  logic [NREQ*PADW-1:0] oe_v;
  logic [PADW-1:0]      c2p;
  logic [PADW-1:0]      c2p_en;
  logic [PADW-1:0]      p2c;
  logic [PADW-1:0]      in_v;
  logic [1:0]           st;

  // second instance: two requesters, one turnaround cycle
  logic [1:0]  req1;
  logic [1:0]  gnt1;
  logic        busy1;
  logic [15:0] out1;
  logic [15:0] oe1;
  logic [7:0]  c2p1;
  logic [7:0]  en1;
  logic [7:0]  p2c1;
  logic [7:0]  in1;
  logic [1:0]  st1;

  pad_bank_arb #(.NREQ(NREQ), .PADW(PADW), .TA_CYC(TA)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .gnt_o(gnt), .busy_o(busy),
    .out_i(out_v), .oe_i(oe_v), .pad_c2p_o(c2p), .pad_c2p_en_o(c2p_en),
    .pad_p2c_i(p2c), .in_o(in_v), .state_o(st)
  );

  pad_bank_arb #(.NREQ(2), .PADW(8), .TA_CYC(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req1), .gnt_o(gnt1), .busy_o(busy1),
    .out_i(out1), .oe_i(oe1), .pad_c2p_o(c2p1), .pad_c2p_en_o(en1),
    .pad_p2c_i(p2c1), .in_o(in1), .state_o(st1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = nobody), turnaround cycles left,
  // most recent owner, and the pad-input history the synchroniser must echo.
  int              m_owner;
  int              m_turn;
  int              m_last;
  logic [PADW-1:0] exp_q[$];

  function automatic void model_reset();
    m_owner = -1;
    m_turn  = 0;
    m_last  = NREQ - 1;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endfunction

  function automatic void model_edge();
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
        m_turn  = TA;
      end
    end else if (m_turn > 0) begin
      m_turn--;
    end else begin
      for (int i = 1; i <= NREQ; i++) begin
        int k;
        k = (m_last + i) % NREQ;
        if (req[k]) begin
          m_owner = k;
          m_last  = k;
          break;
        end
      end
    end
    exp_q.push_back(p2c);
    void'(exp_q.pop_front());
  endfunction

  task automatic check_model();
    logic [NREQ-1:0] eg;
    logic [PADW-1:0] een;
    logic [PADW-1:0] eout;
    eg   = '0;
    een  = '0;
    eout = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      een  = oe_v[m_owner*PADW +: PADW];
      eout = out_v[m_owner*PADW +: PADW];
    end
    check("m_gnt",  32'(gnt),    32'(eg));
    check("m_busy", 32'(busy),   32'((m_owner >= 0) || (m_turn > 0)));
    check("m_en",   32'(c2p_en), 32'(een));
    check("m_c2p",  32'(c2p),    32'(eout));
    check("m_in",   32'(in_v),   32'(exp_q[0]));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge with inputs already set: check, clock, advance model.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("rst_gnt",  32'(gnt),    32'd0);
    check("rst_busy", 32'(busy),   32'd0);
    check("rst_en",   32'(c2p_en), 32'd0);
    check("rst_c2p",  32'(c2p),    32'd0);
    check("rst_in",   32'(in_v),   32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic sync_probe(input string tag);
    p2c = 8'h00;
    tick();
    tick();
    p2c = 8'h01;
    #1 check({tag, "_n0"}, 32'(in_v), 32'h00);
    tick();
    #1 check({tag, "_n1"}, 32'(in_v), 32'h00);
    tick();
    #1 check({tag, "_n2"}, 32'(in_v), 32'h01);
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [PADW-1:0] en;
    logic [PADW-1:0] c2p;
    logic            busy;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int gaps[$];
    int exp_order[5];
    int age;
    int off;
    int was_owner;
    logic [NREQ-1:0] prev_g;
    logic [NREQ-1:0] mask;
    int low1;
    int grants1;
    logic prev1;

    tbl[0]  = '{4'b0000, 4'b0000, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{4'b0001, 4'b0000, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0001, 8'hFF, 8'hA5, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0001, 8'hFF, 8'hA5, 1'b1};
    tbl[4]  = '{4'b0100, 4'b0000, 8'h00, 8'h00, 1'b1};
    tbl[5]  = '{4'b0100, 4'b0000, 8'h00, 8'h00, 1'b1};
    tbl[6]  = '{4'b0100, 4'b0000, 8'h00, 8'h00, 1'b0};
    tbl[7]  = '{4'b0101, 4'b0100, 8'h0F, 8'h22, 1'b1};
    tbl[8]  = '{4'b0001, 4'b0100, 8'h0F, 8'h22, 1'b1};
    tbl[9]  = '{4'b1001, 4'b0000, 8'h00, 8'h00, 1'b1};
    tbl[10] = '{4'b1001, 4'b0000, 8'h00, 8'h00, 1'b1};
    tbl[11] = '{4'b1001, 4'b0000, 8'h00, 8'h00, 1'b0};
    tbl[12] = '{4'b0001, 4'b1000, 8'h3C, 8'h11, 1'b1};
    tbl[13] = '{4'b0001, 4'b0000, 8'h00, 8'h00, 1'b1};
    tbl[14] = '{4'b0001, 4'b0000, 8'h00, 8'h00, 1'b1};
    tbl[15] = '{4'b0001, 4'b0000, 8'h00, 8'h00, 1'b0};
    tbl[16] = '{4'b0000, 4'b0001, 8'hFF, 8'hA5, 1'b1};

    req   = '0;
    out_v = 32'h1122_33A5;
    oe_v  = 32'h3C0F_F0FF;
    p2c   = '0;
    req1  = '0;
    out1  = 16'h5A5A;
    oe1   = 16'hFFFF;
    p2c1  = '0;
    model_reset();

    #2;
    apply_reset();

    // table: grant latency, no preemption, round-robin wrap, oe masking
    for (int i = 0; i < 17; i++) begin
      req = tbl[i].req;
      #1;
      check($sformatf("tbl%0d_gnt", i),  32'(gnt),    32'(tbl[i].gnt));
      check($sformatf("tbl%0d_en", i),   32'(c2p_en), 32'(tbl[i].en));
      check($sformatf("tbl%0d_c2p", i),  32'(c2p),    32'(tbl[i].c2p));
      check($sformatf("tbl%0d_busy", i), 32'(busy),   32'(tbl[i].busy));
      tick();
    end

    // all four requesting, each owner releases after three granted cycles
    apply_reset();
    exp_order = '{0, 1, 2, 3, 0};
    prev_g = '0;
    off    = 0;
    age    = 0;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      req = 4'hF;
      if (m_owner >= 0 && age >= 2) req[m_owner] = 1'b0;
      #1;
      if (gnt != '0 && prev_g == '0) begin
        order.push_back(onehot_idx(gnt));
        gaps.push_back(off);
      end
      if (gnt == '0 && c2p_en == '0) off++;
      else off = 0;
      prev_g    = gnt;
      was_owner = m_owner;
      tick();
      if (m_owner < 0 || was_owner < 0) age = 0;
      else age++;
    end
    check("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size(); i++) begin
      check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
      if (i > 0) check($sformatf("rr_gap%0d", i), 32'(gaps[i]), 32'(TA + 1));
    end

    // synchroniser latency in IDLE and in GRANT
    req = '0;
    for (int i = 0; i < 5; i++) tick();
    sync_probe("sync_idle");
    req = 4'b0001;
    tick();
    tick();
    sync_probe("sync_grant");
    req = '0;
    p2c = '0;
    for (int i = 0; i < 5; i++) tick();

    // reset asserted mid-grant releases pads without a clock edge
    oe_v = '1;
    req  = 4'b0010;
    for (int i = 0; i < 10 && m_owner < 0; i++) tick();
    #1;
    check("pre_rst_en", 32'(c2p_en), 32'hFF);
    rst_n = 1'b0;
    #1;
    check("midrst_en",   32'(c2p_en), 32'h00);
    check("midrst_gnt",  32'(gnt),    32'h0);
    check("midrst_busy", 32'(busy),   32'h0);
    check("midrst_c2p",  32'(c2p),    32'h00);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'hF;
    tick();
    #1 check("rst_first_gnt", 32'(gnt), 32'h1);
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      mask  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      req   = req ^ mask;
      out_v = $urandom;
      oe_v  = $urandom;
      p2c   = 8'($urandom_range(0, 255));
      tick();
    end

    // one-cycle turnaround, lone requester toggling every cycle
    req     = '0;
    low1    = 0;
    grants1 = 0;
    prev1   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      req1 = {1'b0, (c % 2) == 0};
      #1;
      check("ta1_onehot", 32'($countones(gnt1) <= 1), 32'd1);
      if (gnt1 != '0 && !prev1) begin
        if (grants1 > 0) check("ta1_gap", 32'(low1 >= 2), 32'd1);
        grants1++;
      end
      if (gnt1 == '0) low1++;
      else low1 = 0;
      prev1 = (gnt1 != '0);
      tick();
    end
    check("ta1_grants", 32'(grants1 >= 5), 32'd1);
    req1 = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
